// File: rtl/sw_debouncer.sv
// Switch front end: 2-flop synchroniser, per-channel bounce filter, optional rise/fall pulses.
// Optional edge pulses are built only when SW_DEBOUNCE_EDGE_PULSE_EN is defined; otherwise tied to 0.
module sw_debouncer #(
  parameter int WIDTH         = 2,
  parameter int STABLE_CYCLES = 1000,
  parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_sw_raw,
  input  logic             io_sample_en,
  output logic [WIDTH-1:0] io_sw_out,
  output logic [WIDTH-1:0] io_sw_rise,
  output logic [WIDTH-1:0] io_sw_fall
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [CNT_W-1:0] r_cnt     [WIDTH];
  logic [CNT_W-1:0] w_cnt_nxt [WIDTH];
  logic [WIDTH-1:0] w_accept;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= io_sw_raw;
      r_sync2 <= r_sync1;
    end
  end

  // A return to the stable level clears the count, so bounces never accumulate.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (r_sync2[i] == r_stable[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (io_sample_en) begin
        if (r_cnt[i] == CNT_MAX) begin
          w_cnt_nxt[i] = '0;
          w_accept[i]  = 1'b1;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stable <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_stable <= r_stable ^ w_accept;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign io_sw_out = r_stable;

`ifdef SW_DEBOUNCE_EDGE_PULSE_EN
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;

  // Pulses register alongside r_stable so they coincide with the new output level.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= w_accept & r_sync2;
      r_fall <= w_accept & ~r_sync2;
    end
  end

  assign io_sw_rise = r_rise;
  assign io_sw_fall = r_fall;
`else
  assign io_sw_rise = '0;
  assign io_sw_fall = '0;
`endif

endmodule

// File: tb/tb_sw_debouncer.sv
// Directed bench for sw_debouncer (WIDTH=2, STABLE_CYCLES=4); pulse expectations follow the build macro.
module tb_sw_debouncer;

  localparam int W = 2;
`ifdef SW_DEBOUNCE_EDGE_PULSE_EN
  localparam logic PULSE = 1'b1;
`else
  localparam logic PULSE = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] io_sw_raw;
  logic         io_sample_en;
  logic [W-1:0] io_sw_out;
  logic [W-1:0] io_sw_rise;
  logic [W-1:0] io_sw_fall;

  int vectors    = 0;
  int miscompare = 0;

  sw_debouncer #(.WIDTH(W), .STABLE_CYCLES(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_sw_raw    (io_sw_raw),
    .io_sample_en (io_sample_en),
    .io_sw_out    (io_sw_out),
    .io_sw_rise   (io_sw_rise),
    .io_sw_fall   (io_sw_fall)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [W-1:0] e_out,
                     input logic [W-1:0] e_rise, input logic [W-1:0] e_fall);
    logic [W-1:0] er;
    logic [W-1:0] ef;
    er = e_rise & {W{PULSE}};
    ef = e_fall & {W{PULSE}};
    vectors++;
    assert (io_sw_out === e_out) else begin
      miscompare++;
      $error("FAIL %s out: observed %b expected %b", tag, io_sw_out, e_out);
    end
    vectors++;
    assert (io_sw_rise === er) else begin
      miscompare++;
      $error("FAIL %s rise: observed %b expected %b", tag, io_sw_rise, er);
    end
    vectors++;
    assert (io_sw_fall === ef) else begin
      miscompare++;
      $error("FAIL %s fall: observed %b expected %b", tag, io_sw_fall, ef);
    end
  endtask

  initial begin
    // 1. reset
    reset = 1'b1; io_sw_raw = 2'b00; io_sample_en = 1'b1;
    for (int k = 0; k < 3; k++) begin tick(1); chk("reset", 2'b00, 2'b00, 2'b00); end
    reset = 1'b0;
    tick(2); chk("idle", 2'b00, 2'b00, 2'b00);

    // 2. clean rise then fall on channel 0
    io_sw_raw = 2'b01;
    tick(5); chk("rise_e5", 2'b00, 2'b00, 2'b00);
    tick(1); chk("rise_e6", 2'b01, 2'b01, 2'b00);
    tick(1); chk("rise_e7", 2'b01, 2'b00, 2'b00);
    io_sw_raw = 2'b00;
    tick(5); chk("fall_e5", 2'b01, 2'b00, 2'b00);
    tick(1); chk("fall_e6", 2'b00, 2'b00, 2'b01);
    tick(1); chk("fall_e7", 2'b00, 2'b00, 2'b00);

    // 3. three-sample glitch on channel 1 is rejected, then a held level is accepted
    io_sw_raw = 2'b10;
    tick(3);
    io_sw_raw = 2'b00;
    for (int k = 0; k < 6; k++) begin tick(1); chk("glitch", 2'b00, 2'b00, 2'b00); end
    io_sw_raw = 2'b10;
    tick(5); chk("held_e5", 2'b00, 2'b00, 2'b00);
    tick(1); chk("held_e6", 2'b10, 2'b10, 2'b00);
    io_sw_raw = 2'b00;
    tick(6); chk("held_fall", 2'b00, 2'b00, 2'b10);

    // 4. strobed sampling: enable high on odd edges only
    io_sw_raw = 2'b11; io_sample_en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      io_sample_en = logic'((k + 1) & 1);
      chk("strobe_wait", 2'b00, 2'b00, 2'b00);
    end
    tick(1); chk("strobe_acc", 2'b11, 2'b11, 2'b00);
    tick(1); chk("strobe_after", 2'b11, 2'b00, 2'b00);
    io_sample_en = 1'b1; io_sw_raw = 2'b00;
    tick(6); chk("both_fall", 2'b00, 2'b00, 2'b11);

    // 5. reset after two qualifying samples discards the count
    io_sw_raw = 2'b01;
    tick(4);
    reset = 1'b1;
    tick(1); chk("mid_rst", 2'b00, 2'b00, 2'b00);
    tick(1); chk("mid_rst2", 2'b00, 2'b00, 2'b00);
    reset = 1'b0;
    tick(5); chk("post_rst_e5", 2'b00, 2'b00, 2'b00);
    tick(1); chk("post_rst_e6", 2'b01, 2'b01, 2'b00);
    tick(1); chk("post_rst_e7", 2'b01, 2'b00, 2'b00);

    // reset coinciding with the acceptance edge wins
    io_sw_raw = 2'b00;
    tick(5); chk("pre_acc", 2'b01, 2'b00, 2'b00);
    reset = 1'b1;
    tick(1); chk("rst_acc", 2'b00, 2'b00, 2'b00);
    reset = 1'b0;
    tick(8); chk("final", 2'b00, 2'b00, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompare);
    $finish;
  end

endmodule
